// File: rtl/ahb_lite_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_master_pkg
// Description : Shared AHB-lite constants and request legality helper for the
//               AHB-lite master and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_lite_master_pkg;

    localparam int WORD_WIDTH = 32;

    // AHB transfer types used by a single-transfer master
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // AHB-lite slave responses
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Burst type: this master only ever issues SINGLE transfers
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Bus transfer sizes
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // A request is illegal for an unsupported size or a misaligned address.
    function automatic logic req_is_illegal(input logic [1:0] size,
                                            input logic [1:0] addr_lsb);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr_lsb[0];
            2'd2:    bad = (addr_lsb != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_lite_master_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_master_if
// Description : Core request/response channels plus AHB-lite bus signals of
//               the AHB-lite master. "master" is the bus master's view,
//               "slave" is the view of the core + bus fabric around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_lite_master_if;
    import ahb_lite_master_pkg::*;

    // Core request channel
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [WORD_WIDTH-1:0] req_addr;
    logic [1:0]            req_size;
    logic [WORD_WIDTH-1:0] req_wdata;

    // Core response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WORD_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    // AHB-lite bus
    logic [WORD_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic [WORD_WIDTH-1:0] HWDATA;
    logic [WORD_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic [1:0]            HRESP;

    modport master (
        input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
        input  HRDATA, HREADY, HRESP,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HWRITE, HSIZE, HBURST, HTRANS, HMASTLOCK, HWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
        output HRDATA, HREADY, HRESP,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HWRITE, HSIZE, HBURST, HTRANS, HMASTLOCK, HWDATA
    );

endinterface
`default_nettype wire

// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_master
// Description : Single-outstanding AHB-lite master. Converts one core request
//               into one SINGLE transfer and returns data/error status on a
//               valid/ready response channel. A wait-state timeout protects
//               against hung slaves. TIMEOUT must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_master
    import ahb_lite_master_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ahb_lite_master_if.master  bus
);

    // Counter only has to reach TIMEOUT-1; the edge that would make it
    // TIMEOUT is the abort edge itself.
    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                r_state,     w_state_nxt;
    logic [1:0]            r_htrans,    w_htrans_nxt;
    logic [WORD_WIDTH-1:0] r_haddr,     w_haddr_nxt;
    logic                  r_hwrite,    w_hwrite_nxt;
    logic [2:0]            r_hsize,     w_hsize_nxt;
    logic [WORD_WIDTH-1:0] r_hwdata,    w_hwdata_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic                  r_rsp_err,   w_rsp_err_nxt;
    logic [WORD_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic                  r_sticky,    w_sticky_nxt;
    logic [CNT_W-1:0]      r_cnt,       w_cnt_nxt;

    logic w_err_now;
    logic w_fail;

    assign w_err_now = (bus.HRESP == HRESP_ERROR);
    assign w_fail    = r_sticky | w_err_now;

    // State and all registered bus/response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_htrans    <= HTRANS_IDLE;
            r_haddr     <= '0;
            r_hwrite    <= 1'b0;
            r_hsize     <= HSIZE_WORD;
            r_hwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_sticky    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_htrans    <= w_htrans_nxt;
            r_haddr     <= w_haddr_nxt;
            r_hwrite    <= w_hwrite_nxt;
            r_hsize     <= w_hsize_nxt;
            r_hwdata    <= w_hwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_sticky    <= w_sticky_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // Next-state and next-output logic of the transfer FSM
    always_comb begin
        w_state_nxt     = r_state;
        w_htrans_nxt    = r_htrans;
        w_haddr_nxt     = r_haddr;
        w_hwrite_nxt    = r_hwrite;
        w_hsize_nxt     = r_hsize;
        w_hwdata_nxt    = r_hwdata;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_sticky_nxt    = r_sticky;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (req_is_illegal(bus.req_size, bus.req_addr[1:0])) begin
                        // Rejected without touching the bus
                        w_state_nxt     = ST_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end else begin
                        w_state_nxt  = ST_ADDR;
                        w_htrans_nxt = HTRANS_NONSEQ;
                        w_haddr_nxt  = bus.req_addr;
                        w_hwrite_nxt = bus.req_write;
                        w_hsize_nxt  = {1'b0, bus.req_size};
                        w_hwdata_nxt = bus.req_wdata;
                        w_cnt_nxt    = '0;
                    end
                end
            end

            ST_ADDR: begin
                if (bus.HREADY) begin
                    w_state_nxt  = ST_DATA;
                    w_htrans_nxt = HTRANS_IDLE;
                    w_cnt_nxt    = '0;
                    w_sticky_nxt = 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt     = ST_RESP;
                    w_htrans_nxt    = HTRANS_IDLE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (bus.HREADY) begin
                    // An ERROR seen earlier in the phase or on this edge fails
                    // the transfer and suppresses read data.
                    w_state_nxt     = ST_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = w_fail;
                    w_rsp_rdata_nxt = (!r_hwrite && !w_fail) ? bus.HRDATA : '0;
                end else begin
                    w_sticky_nxt = w_fail;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt     = ST_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.HADDR     = r_haddr;
    assign bus.HWRITE    = r_hwrite;
    assign bus.HSIZE     = r_hsize;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HTRANS    = r_htrans;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = r_hwdata;

endmodule
`default_nettype wire

// File: doc/ahb_lite_master.md
# ahb_lite_master

Single-outstanding AHB-lite bus master that turns a valid/ready request from the core load/store path into one AHB-lite SINGLE transfer and returns read data and error status over a valid/ready response channel. It sits between the core and the bus decoder/multiplexer, and is the initiating end of the same AHB-lite protocol the memory-mapped peripherals answer, such as the digital-tube and LED blocks. It covers registered slave responses, slaves that hold HREADY low on an address error, and hung slaves (via a timeout).

## Interface
Parameters:
- TIMEOUT, 16: maximum consecutive HREADY-low cycles tolerated in one phase before abort (≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous and active-low, with one clock.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  `WORD_WIDTH  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_wdata  in  `WORD_WIDTH  write data.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  `WORD_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  transfer failed: bus ERROR, misalignment, illegal size, or timeout.
- HADDR  out  `WORD_WIDTH; HWRITE out 1; HSIZE out 3; HBURST out 3; HTRANS out 2; HMASTLOCK out 1; HWDATA out `WORD_WIDTH.
- HRDATA  in  `WORD_WIDTH; HREADY in 1; HRESP in 2.

## Operation
- States: IDLE, ADDR, DATA, RESP.
- **IDLE.** req_ready = 1 only in IDLE. On the handshake:
  - If the request is legal, latch it and go to ADDR.
  - If size = 3, or the address is misaligned (half: addr[0] ≠ 0; word: addr[1:0] ≠ 0), go to RESP with rsp_err = 1. No bus transfer is issued.
- **ADDR.**
  - Drive HTRANS = `HTRANS_NONSEQ, plus HADDR, HWRITE and HSIZE = {1'b0, size}.
  - HREADY = 1 at the clock edge: go to DATA.
  - HREADY = 0: stay and count.
- **DATA.**
  - Drive HTRANS = `HTRANS_IDLE. HWDATA carries the latched write data; it is held from ADDR entry until DATA exit.
  - A sticky error flag sets on any DATA-cycle edge with HRESP = `HRESP_ERROR, whether HREADY is high or low.
  - On the edge with HREADY = 1:
    - Capture HRDATA into rsp_rdata if this is a read with no error; otherwise rsp_rdata = 0.
    - rsp_err = sticky flag OR current ERROR.
    - Go to RESP.
- **Timeout.** A counter clears on entry to ADDR and on entry to DATA, and increments on each HREADY-low edge. When it reaches TIMEOUT:
  - Go to RESP with rsp_err = 1 and HTRANS = IDLE.
  - A late HREADY for that transfer is ignored.
- **RESP.** rsp_valid = 1. When rsp_ready = 1, go to IDLE.
- Constant outputs: HBURST = 3'b000 (SINGLE), HMASTLOCK = 0.
- Reset values: state IDLE; HTRANS IDLE; HADDR, HWDATA and rsp_rdata 0; HWRITE 0; HSIZE 3'b010; rsp_valid 0; rsp_err 0; sticky flag and counter 0.
- Reset asserted in any state returns to IDLE at the next edge and drops any in-flight transfer and response.

## Timing
- All bus and response outputs are registered.
- req_ready is combinational from state only; it never depends on req_valid.
- Zero-wait slave:
  - Handshake edge E0.
  - ADDR phase is the cycle E0–E1.
  - DATA phase is E1–E2.
  - rsp_valid is high from E2.
  - This gives 2 cycles of latency.
- Each wait state adds one cycle.
- Back-to-back throughput: a new request can be accepted in the cycle after the rsp_ready handshake, so the minimum period is 4 cycles.
- Illegal request: rsp_valid is high in the cycle after the handshake.
- The HRESP ERROR sample and HREADY completion may occur on the same edge; the result is a completion with rsp_err = 1.
- HREADY low at the reset release edge: the first transfer waits in ADDR, which is covered by the timeout.

## Structure
- Shared package / defines file:
  - `WORD_WIDTH, `HTRANS_IDLE/NONSEQ, `HRESP_OKAY/ERROR.
  - New constants `HBURST_SINGLE and `HSIZE_BYTE/HALF/WORD.
  - The state encoding localparam stays local.
- Single flat module. No sub-module: the timeout counter is too small to justify one.

## Test plan
- **Zero-wait word write, addr 0x1000_0004, data 0x5.** Expected: NONSEQ for 1 cycle with HSIZE = 2, HWDATA = 0x5 in the following cycle, rsp_valid 2 cycles after the handshake with rsp_err = 0.
- **Read with 2 wait states, HRDATA = 0x0000_000A at completion.** Expected: rsp_rdata = 0xA, rsp_err = 0, latency 4 cycles.
- **Read to an unmapped address; slave returns HREADY = 0 / ERROR for 1 cycle, then HREADY = 1 / OKAY.** Expected: rsp_err = 1, rsp_rdata = 0.
- **Half-word request at 0x...03, and separately size = 3.** Expected: HTRANS never leaves IDLE; rsp_err = 1 one cycle after the handshake.
- **HREADY held low forever with TIMEOUT = 16.** Expected: rsp_err = 1 after 16 low cycles; a later HREADY pulse causes no second response.
- **rsp_ready held low for 5 cycles, then rst_n = 0 for one edge.** Expected: rsp_valid stays high until the reset edge, then all outputs are at reset values and req_ready = 1.
